playback_ctrl: RTL and testbench
================================

Name: playback_ctrl

Overview:
Avalon-MM slave that sequences the audio playback/record datapath from the front-panel buttons and from Nios software.
- Synchronizes and debounces the play, stop and record buttons.
- Runs a transport state machine (IDLE/PLAY/PAUSE/RECORD) and advances a sample address counter on each audio sample tick.
- Raises an interrupt on state changes, end-of-track and record-full.
- Sits between the board buttons, the Nios data master and the audio sample buffer.

Parameters:
ADDR_W, 16, width of sample address counter and length register
DEBOUNCE_CYCLES, 500000, stable cycles required before a button level is accepted (minimum 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  interrupt, level
play_btn  in  1  raw play button, active-high, asynchronous
stop_btn  in  1  raw stop button, active-high, asynchronous
rec_btn  in  1  raw record button, active-high, asynchronous
sample_tick  in  1  one-cycle pulse per audio sample
play_en  out  1  high in PLAY
rec_en  out  1  high in RECORD
sample_addr  out  ADDR_W  current buffer position
state  out  2  transport state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 RECORD

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). All state updates on rising clk.
- Reset values:
  - readdata=0, irq=0, play_en=0, rec_en=0, sample_addr=0, state=IDLE.
  - Events=0, mask=0, loop_en=0, length=2^ADDR_W-1, debounce counters=0, stable levels=0.
- Button path, per button:
  - 2-FF synchronizer feeds a counter.
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 the stable level takes the synchronized value and the counter clears.
  - Press = one-cycle pulse on the stable 0->1 transition. Releases generate nothing.
- Commands: press pulses are ORed with software commands from a CTRL write (bit0 play, bit1 stop, bit2 rec; one-cycle effect).
- Simultaneous-command priority: stop > rec > play. Only one command acts per cycle.
- FSM transitions:
  - stop: any state -> IDLE, sample_addr=0.
  - rec: IDLE -> RECORD, sample_addr=0. Ignored in other states.
  - play: IDLE -> PLAY from sample_addr 0; PLAY -> PAUSE; PAUSE -> PLAY. Ignored in RECORD.
- Counter:
  - In PLAY or RECORD, sample_tick increments sample_addr.
  - If sample_addr==length on a tick:
    - PLAY with loop_en=1: sample_addr=0, stays PLAY, sets ev_end.
    - PLAY with loop_en=0: -> IDLE, sample_addr=0, sets ev_end.
    - RECORD: -> IDLE, sample_addr=0, sets ev_full.
  - A command in the same cycle as a tick takes precedence; the tick is dropped.
  - PAUSE holds sample_addr and ignores ticks.
- Outputs play_en, rec_en and state are decoded combinationally from the state register. No extra latency.
- Registers (word addresses); readdata is registered with 1-cycle latency and is updated every cycle from address, independent of chipselect:
  - 0 STATUS (RO): [1:0] state, [4:2] stable play/stop/rec levels.
  - 1 CTRL: write [2:0] commands, [3] loop_en. Read returns {loop_en,3'b0}.
  - 2 LENGTH: [ADDR_W-1:0] last valid address. A write of 0 is ignored. A write while PLAY/RECORD takes effect at the next compare.
  - 3 POS (RO): sample_addr.
  - 4 IRQ_MASK: [2:0] mask.
  - 5 EVENTS: [0] ev_state (any state change), [1] ev_end, [2] ev_full. Write-1-to-clear. If an event sets in the same cycle as its clear, set wins.
  - 6, 7: read 0, writes ignored.
- irq = |(EVENTS & IRQ_MASK), combinational from registers.
- Reset mid-operation: returns to the reset values on the next edge. Pending debounce is discarded.

Test Plan:
- Debounce: DEBOUNCE_CYCLES=4; play_btn high for 3 cycles then low -> no transition. Held 10 cycles -> state=1 exactly 2+4+1 cycles after the rise, one press only.
- Bounce: play_btn toggles every 2 cycles for 20 cycles, then holds high -> exactly one PLAY transition, after the hold settles.
- Counter/end: LENGTH=3, loop_en=0, play, 4 ticks -> sample_addr 1,2,3,0; state returns 0; EVENTS=3'b011. With mask=2, irq=1; write EVENTS=2 -> irq=0 next cycle.
- Loop/pause: loop_en=1, LENGTH=1, play, ticks -> sample_addr 0,1,0,1, state stays 1. Play press -> state=2; ticks leave sample_addr unchanged.
- Priority: CTRL write 3'b111 in PLAY with a coincident tick -> state=0, sample_addr=0. CTRL write 3'b101 in IDLE -> state=3 (rec wins over play).
- Record full: LENGTH=2, rec_btn press, 3 ticks -> rec_en high for 3 ticks, then state=0, EVENTS[2]=1; reset asserted mid-record -> all outputs 0 next cycle.

Source files
------------

// File: rtl/playback_ctrl.sv
// Transport controller for the audio sample buffer: debounced front-panel buttons and
// Avalon-MM register commands drive an IDLE/PLAY/PAUSE/RECORD sequencer and address counter.
module playback_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic              play_btn,
    input  logic              stop_btn,
    input  logic              rec_btn,
    input  logic              sample_tick,
    output logic              play_en,
    output logic              rec_en,
    output logic [ADDR_W-1:0] sample_addr,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECORD = 2'd3
    } state_t;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_LENGTH = 3'd2;
    localparam logic [2:0] REG_POS    = 3'd3;
    localparam logic [2:0] REG_MASK   = 3'd4;
    localparam logic [2:0] REG_EVENTS = 3'd5;

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Command / button bit order throughout: 0 play, 1 stop, 2 rec.
    localparam int CMD_PLAY = 0;
    localparam int CMD_STOP = 1;
    localparam int CMD_REC  = 2;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [2:0]       btn_raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       stable;
    logic [2:0]       press;
    logic [CNT_W-1:0] db_cnt [3];

    assign btn_raw = {rec_btn, stop_btn, play_btn};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            stable <= '0;
            press  <= '0;
            // NOTE: the counter array is only three entries, so it is reset like
            // any other flop; a pending debounce must not survive reset.
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make sync_b take the old sync_a,
            // giving a true two-stage synchronizer.
            sync_a <= btn_raw;
            sync_b <= sync_a;
            press  <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    stable[i] <= sync_b[i];
                    press[i]  <= sync_b[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus decode and command merge
    // ------------------------------------------------------------------
    logic       bus_wr;
    logic [2:0] sw_cmd;
    logic [2:0] cmd;
    logic       unused_wdata;

    assign bus_wr = chipselect & ~write_n;
    assign sw_cmd = (bus_wr && address == REG_CTRL) ? writedata[2:0] : 3'b000;
    assign cmd    = press | sw_cmd;

    // Upper write-data bits have no register behind them.
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Transport FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] length;
    logic              loop_en;
    logic              set_end;
    logic              set_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= next_state;
            addr_q  <= next_addr;
        end
    end

    // Highest-priority asserted command is the only one considered; any command
    // in a tick cycle swallows that tick.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned and infer a latch.
        next_state = state_q;
        next_addr  = addr_q;
        set_end    = 1'b0;
        set_full   = 1'b0;
        if (cmd[CMD_STOP]) begin
            next_state = ST_IDLE;
            next_addr  = '0;
        end else if (cmd[CMD_REC]) begin
            if (state_q == ST_IDLE) begin
                next_state = ST_RECORD;
                next_addr  = '0;
            end
        end else if (cmd[CMD_PLAY]) begin
            case (state_q)
                ST_IDLE: begin
                    next_state = ST_PLAY;
                    next_addr  = '0;
                end
                ST_PLAY:  next_state = ST_PAUSE;
                ST_PAUSE: next_state = ST_PLAY;
                default:  next_state = state_q;
            endcase
        end else if (sample_tick && (state_q == ST_PLAY || state_q == ST_RECORD)) begin
            if (addr_q == length) begin
                next_addr = '0;
                if (state_q == ST_RECORD) begin
                    next_state = ST_IDLE;
                    set_full   = 1'b1;
                end else begin
                    set_end = 1'b1;
                    if (!loop_en) begin
                        next_state = ST_IDLE;
                    end
                end
            end else begin
                next_addr = addr_q + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Software-visible registers
    // ------------------------------------------------------------------
    logic [2:0]  mask;
    logic [2:0]  events;
    logic [2:0]  ev_set;
    logic [2:0]  ev_clr;
    logic [31:0] rd_mux;

    assign ev_set = {set_full, set_end, next_state != state_q};
    assign ev_clr = (bus_wr && address == REG_EVENTS) ? writedata[2:0] : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            loop_en  <= 1'b0;
            length   <= '1;
            mask     <= '0;
            events   <= '0;
            readdata <= '0;
        end else begin
            if (bus_wr && address == REG_CTRL) begin
                loop_en <= writedata[3];
            end
            if (bus_wr && address == REG_LENGTH && writedata[ADDR_W-1:0] != '0) begin
                length <= writedata[ADDR_W-1:0];
            end
            if (bus_wr && address == REG_MASK) begin
                mask <= writedata[2:0];
            end
            // Set wins over a simultaneous write-1-to-clear.
            events   <= (events & ~ev_clr) | ev_set;
            readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS: rd_mux = {27'd0, stable[CMD_REC], stable[CMD_STOP], stable[CMD_PLAY], state_q};
            REG_CTRL:   rd_mux = {28'd0, loop_en, 3'b000};
            REG_LENGTH: rd_mux = 32'(length);
            REG_POS:    rd_mux = 32'(addr_q);
            REG_MASK:   rd_mux = {29'd0, mask};
            REG_EVENTS: rd_mux = {29'd0, events};
            default:    rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq         = |(events & mask);
    assign state       = state_q;
    assign play_en     = (state_q == ST_PLAY);
    assign rec_en      = (state_q == ST_RECORD);
    assign sample_addr = addr_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed self-checking bench for playback_ctrl: debounce, bounce rejection, end-of-track,
// looping/pause, command priority, record-full and mid-operation reset.
module tb_playback_ctrl;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_LENGTH = 3'd2;
    localparam logic [2:0] REG_POS    = 3'd3;
    localparam logic [2:0] REG_MASK   = 3'd4;
    localparam logic [2:0] REG_EVENTS = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic        play_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic        rec_btn = 1'b0;
    logic        sample_tick = 1'b0;
    logic        play_en;
    logic        rec_en;
    logic [15:0] sample_addr;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    playback_ctrl #(.ADDR_W(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .play_btn(play_btn), .stop_btn(stop_btn), .rec_btn(rec_btn),
        .sample_tick(sample_tick), .play_en(play_en), .rec_en(rec_en),
        .sample_addr(sample_addr), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step();
        d = readdata;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        step_n(2);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (play_en !== 1'b0 || rec_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got play_en=%b rec_en=%b want 0/0", play_en, rec_en); end
        n_cmp++; if (sample_addr !== 16'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", sample_addr); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", readdata); end
        reset = 1'b0;
        bus_read(REG_LENGTH, rd);
        n_cmp++; if (rd !== 32'h0000_FFFF) begin n_err++; $display("FAIL reset_length: got %h want 0000ffff", rd); end
        bus_read(REG_CTRL, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        bus_read(REG_EVENTS, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_events: got %h want 0", rd); end
    endtask

    task automatic test_debounce();
        logic [31:0] rd;
        play_btn = 1'b1;
        step_n(3);
        play_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL debounce_short_pulse cycle %0d: got %0d want 0", i, state); end
        end
        play_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (state !== ((k >= 7) ? 2'd1 : 2'd0)) begin
                n_err++; $display("FAIL debounce_hold cycle %0d: got %0d want %0d", k, state, (k >= 7) ? 1 : 0);
            end
        end
        play_btn = 1'b0;
        step_n(12);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL debounce_single_press: got %0d want 1", state); end
        bus_read(REG_STATUS, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL debounce_status: got %h want 1", rd); end
        bus_write(REG_CTRL, 32'h2);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL debounce_stop: got %0d want 0", state); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            play_btn = ((i / 2) % 2 == 0);
            step();
            n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL bounce_reject cycle %0d: got %0d want 0", i, state); end
        end
        play_btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_cmp++;
            if (state !== ((k == 7) ? 2'd1 : 2'd0)) begin
                n_err++; $display("FAIL bounce_settle cycle %0d: got %0d want %0d", k, state, (k == 7) ? 1 : 0);
            end
        end
        play_btn = 1'b0;
        step_n(12);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL bounce_single_press: got %0d want 1", state); end
        bus_write(REG_CTRL, 32'h2);
    endtask

    task automatic test_counter_end();
        logic [31:0] rd;
        logic [15:0] exp_addr [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
        bus_write(REG_EVENTS, 32'h7);
        bus_write(REG_LENGTH, 32'd3);
        bus_write(REG_CTRL, 32'h1);
        n_cmp++; if (state !== 2'd1 || sample_addr !== 16'd0) begin n_err++; $display("FAIL end_start: got state=%0d addr=%0d want 1/0", state, sample_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (sample_addr !== exp_addr[i]) begin n_err++; $display("FAIL end_addr tick %0d: got %0d want %0d", i, sample_addr, exp_addr[i]); end
        end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL end_state: got %0d want 0", state); end
        bus_read(REG_EVENTS, rd);
        n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL end_events: got %h want 3", rd); end
        bus_read(REG_POS, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL end_pos: got %h want 0", rd); end
        bus_write(REG_MASK, 32'h2);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL end_irq_set: got %b want 1", irq); end
        bus_write(REG_EVENTS, 32'h2);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL end_irq_clear: got %b want 0", irq); end
        bus_read(REG_EVENTS, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL end_events_after_clear: got %h want 1", rd); end
        bus_write(REG_MASK, 32'h0);
    endtask

    task automatic test_loop_pause();
        logic [31:0] rd;
        logic [15:0] exp_addr [3] = '{16'd1, 16'd0, 16'd1};
        bus_write(REG_EVENTS, 32'h7);
        bus_write(REG_LENGTH, 32'd1);
        bus_write(REG_CTRL, 32'h9);
        n_cmp++; if (state !== 2'd1 || sample_addr !== 16'd0) begin n_err++; $display("FAIL loop_start: got state=%0d addr=%0d want 1/0", state, sample_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (sample_addr !== exp_addr[i] || state !== 2'd1) begin
                n_err++; $display("FAIL loop_tick %0d: got addr=%0d state=%0d want %0d/1", i, sample_addr, state, exp_addr[i]);
            end
        end
        bus_read(REG_CTRL, rd);
        n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL loop_ctrl_read: got %h want 8", rd); end
        play_btn = 1'b1;
        step_n(6);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL pause_early: got %0d want 1", state); end
        step();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL pause_enter: got %0d want 2", state); end
        play_btn = 1'b0;
        step_n(12);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (sample_addr !== 16'd1 || state !== 2'd2) begin
                n_err++; $display("FAIL pause_hold tick %0d: got addr=%0d state=%0d want 1/2", i, sample_addr, state);
            end
        end
        bus_read(REG_EVENTS, rd);
        n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL loop_events: got %h want 3", rd); end
    endtask

    task automatic test_priority();
        bus_write(REG_LENGTH, 32'd5);
        bus_write(REG_CTRL, 32'h9);
        n_cmp++; if (state !== 2'd1 || sample_addr !== 16'd1) begin n_err++; $display("FAIL prio_resume: got state=%0d addr=%0d want 1/1", state, sample_addr); end
        sample_tick = 1'b1;
        bus_write(REG_CTRL, 32'h7);
        sample_tick = 1'b0;
        n_cmp++; if (state !== 2'd0 || sample_addr !== 16'd0) begin n_err++; $display("FAIL prio_stop_tick: got state=%0d addr=%0d want 0/0", state, sample_addr); end
        bus_write(REG_CTRL, 32'h5);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL prio_rec_over_play: got %0d want 3", state); end
        n_cmp++; if (rec_en !== 1'b1 || play_en !== 1'b0) begin n_err++; $display("FAIL prio_enables: got rec_en=%b play_en=%b want 1/0", rec_en, play_en); end
        bus_write(REG_CTRL, 32'h1);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL prio_play_in_record: got %0d want 3", state); end
        bus_write(REG_CTRL, 32'h2);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL prio_final_stop: got %0d want 0", state); end
    endtask

    task automatic test_record_full();
        logic [31:0] rd;
        logic [15:0] exp_addr [3] = '{16'd1, 16'd2, 16'd0};
        bus_write(REG_EVENTS, 32'h7);
        bus_write(REG_LENGTH, 32'd2);
        rec_btn = 1'b1;
        step_n(7);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL rec_press: got %0d want 3", state); end
        rec_btn = 1'b0;
        step_n(12);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rec_en !== 1'b1) begin n_err++; $display("FAIL rec_en before tick %0d: got %b want 1", i, rec_en); end
            tick();
            n_cmp++; if (sample_addr !== exp_addr[i]) begin n_err++; $display("FAIL rec_addr tick %0d: got %0d want %0d", i, sample_addr, exp_addr[i]); end
        end
        n_cmp++; if (state !== 2'd0 || rec_en !== 1'b0) begin n_err++; $display("FAIL rec_full_state: got state=%0d rec_en=%b want 0/0", state, rec_en); end
        bus_read(REG_EVENTS, rd);
        n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL rec_full_events: got %h want 5", rd); end

        bus_write(REG_CTRL, 32'h4);
        tick();
        bus_write(REG_MASK, 32'h7);
        n_cmp++; if (irq !== 1'b1 || state !== 2'd3 || sample_addr !== 16'd1) begin
            n_err++; $display("FAIL rec_pre_reset: got irq=%b state=%0d addr=%0d want 1/3/1", irq, state, sample_addr);
        end
        play_btn = 1'b1;
        step_n(3);
        reset = 1'b1;
        step();
        n_cmp++; if (state !== 2'd0 || sample_addr !== 16'd0) begin n_err++; $display("FAIL midreset_state: got state=%0d addr=%0d want 0/0", state, sample_addr); end
        n_cmp++; if (rec_en !== 1'b0 || play_en !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: got rec_en=%b play_en=%b irq=%b want 0/0/0", rec_en, play_en, irq);
        end
        n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL midreset_readdata: got %h want 0", readdata); end
        play_btn = 1'b0;
        reset = 1'b0;
        step_n(12);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL midreset_debounce_discard: got %0d want 0", state); end
        bus_read(REG_MASK, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL midreset_mask: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_bounce();
        test_counter_end();
        test_loop_pause();
        test_priority();
        test_record_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
